mxu_ws_array: RTL

- Parametrised weight-stationary systolic MXU; next generation of the MAC-grid core.
- Adds weight preload, input skewing, output deskewing, valid/ready streaming with backpressure, a control FSM, signed/unsigned mode and a configurable accumulator width.
- Sits between the activation/weight buffers and the output FIFO of the DTPU datapath.

---
 rtl/mxu_ws_array_pkg.sv | 20 ++
 rtl/mxu_ws_array_pe.sv | 61 ++++++
 rtl/mxu_ws_array.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mxu_ws_array_pkg.sv
// Shared definitions for the weight-stationary MXU.
// FSM encoding plus latency and accumulator-width helpers.
package mxu_ws_array_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  function automatic int lat_of(input int m, input int k);
    return m + k - 1;
  endfunction

  function automatic int acc_w_of(input int dw, input int k);
    return 2 * dw + $clog2(k);
  endfunction

endpackage

// File: rtl/mxu_ws_array_pe.sv
// One processing element: stationary weight, data-down register,
// MAC and right-flowing partial-sum register.
module mxu_ws_pe #(
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 18,
  parameter int USE_FABRIC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              w_we,
  input  logic [DATA_W-1:0] w_in,
  input  logic              sm,
  input  logic [DATA_W-1:0] x_in,
  output logic [DATA_W-1:0] x_out,
  input  logic [ACC_W-1:0]  psum_in,
  output logic [ACC_W-1:0]  psum_out
);

  logic [DATA_W-1:0] w_q;
  logic [DATA_W-1:0] x_q;
  logic [ACC_W-1:0]  ps_q;
  logic [ACC_W-1:0]  we;
  logic [ACC_W-1:0]  xe;
  logic [ACC_W-1:0]  prod;

  // low ACC_W bits of the product are right for both signednesses
  assign we = {{(ACC_W-DATA_W){sm & w_q[DATA_W-1]}}, w_q};
  assign xe = {{(ACC_W-DATA_W){sm & x_in[DATA_W-1]}}, x_in};

  if (USE_FABRIC != 0) begin : g_fab
    logic [ACC_W-1:0] acc_f;
    always_comb begin
      acc_f = '0;
      for (int b = 0; b < ACC_W; b++) begin
        if (xe[b]) acc_f = acc_f + (we << b);
      end
    end
    assign prod = acc_f;
  end else begin : g_dsp
    assign prod = we * xe;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q  <= '0;
      x_q  <= '0;
      ps_q <= '0;
    end else begin
      if (w_we) w_q <= w_in;
      if (ce) begin
        x_q  <= x_in;
        ps_q <= psum_in + prod;
      end
    end
  end

  assign x_out    = x_q;
  assign psum_out = ps_q;

endmodule

// File: rtl/mxu_ws_array.sv
// Weight-stationary systolic MXU: skewed inputs, PE grid,
// deskewed outputs, valid/ready streaming and load/run FSM.
module mxu_ws_array
  import mxu_ws_array_pkg::*;
#(
  parameter int M             = 3,
  parameter int K             = 3,
  parameter int DATA_W        = 8,
  parameter int ACC_W         = acc_w_of(DATA_W, K),
  parameter int MAX_BOARD_DSP = 220
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                signed_mode,
  input  logic                w_load_valid,
  output logic                w_load_ready,
  input  logic [K*DATA_W-1:0] w_load_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [K*DATA_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [M*ACC_W-1:0]  out_data,
  output logic                busy
);

  localparam int LAT   = lat_of(M, K);
  localparam int ROW_W = (M > 1) ? $clog2(M) : 1;

  state_e             state_q;
  state_e             state_d;
  logic [ROW_W-1:0]   row_q;
  logic [ROW_W-1:0]   row_d;
  logic               sm_q;
  logic               sm_d;
  logic [ROW_W-1:0]   w_row;
  logic               w_fire;
  logic               w_rdy;
  logic               in_rdy;
  logic               in_fire;
  logic               adv;
  logic [LAT-1:0]     vpipe;
  logic [K*DATA_W-1:0] x_src;
  logic [K*DATA_W-1:0] col_x;

  logic [M-1:0][K-1:0][DATA_W-1:0] x_bus;
  logic [M-1:0][K-1:0][ACC_W-1:0]  ps_bus;
  logic                            unused_x;

  assign adv     = enable && !(out_valid && !out_ready);
  assign in_fire = in_valid && in_ready;
  assign x_src   = in_fire ? in_data : '0;

  assign w_load_ready = w_rdy && !reset;
  assign in_ready     = in_rdy && !reset;
  assign out_valid    = vpipe[LAT-1];
  assign busy         = (|vpipe) || (state_q == ST_LOAD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      sm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      sm_q    <= sm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    sm_d    = sm_q;
    w_fire  = 1'b0;
    w_rdy   = 1'b0;
    in_rdy  = 1'b0;
    w_row   = row_q;
    unique case (state_q)
      ST_IDLE: begin
        w_rdy = adv;
        w_row = '0;
        if (adv && w_load_valid) begin
          w_fire  = 1'b1;
          sm_d    = signed_mode;
          row_d   = (M == 1) ? '0 : ROW_W'(1);
          state_d = (M == 1) ? ST_RUN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_rdy = adv;
        if (adv && w_load_valid) begin
          w_fire = 1'b1;
          row_d  = row_q + ROW_W'(1);
          if (row_q == ROW_W'(M - 1)) begin
            row_d   = '0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // a pending reload wins over new data
        in_rdy = adv && !w_load_valid;
        if (adv && w_load_valid) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (adv && vpipe == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) vpipe <= '0;
    else if (adv) vpipe <= (vpipe << 1) | LAT'(in_fire);
  end

  for (genvar k = 0; k < K; k++) begin : g_skew
    if (k == 0) begin : g_direct
      assign col_x[0 +: DATA_W] = x_src[0 +: DATA_W];
    end else begin : g_reg
      logic [DATA_W-1:0] sr [k];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int j = 0; j < k; j++) sr[j] <= '0;
        end else if (adv) begin
          sr[0] <= x_src[k*DATA_W +: DATA_W];
          for (int j = 1; j < k; j++) sr[j] <= sr[j-1];
        end
      end
      assign col_x[k*DATA_W +: DATA_W] = sr[k-1];
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar k = 0; k < K; k++) begin : g_col
      logic [DATA_W-1:0] x_in;
      logic [ACC_W-1:0]  p_in;
      logic              w_we;

      if (i == 0) begin : g_xtop
        assign x_in = col_x[k*DATA_W +: DATA_W];
      end else begin : g_xdn
        assign x_in = x_bus[i-1][k];
      end

      if (k == 0) begin : g_pl
        assign p_in = '0;
      end else begin : g_pr
        assign p_in = ps_bus[i][k-1];
      end

      assign w_we = w_fire && (w_row == ROW_W'(i));

      mxu_ws_pe #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .USE_FABRIC((i * K + k) >= MAX_BOARD_DSP ? 1 : 0)
      ) u_pe (
        .clk     (clk),
        .reset   (reset),
        .ce      (adv),
        .w_we    (w_we),
        .w_in    (w_load_data[k*DATA_W +: DATA_W]),
        .sm      (sm_q),
        .x_in    (x_in),
        .x_out   (x_bus[i][k]),
        .psum_in (p_in),
        .psum_out(ps_bus[i][k])
      );
    end
  end

  assign unused_x = ^x_bus[M-1];

  // row i leaves early by M-1-i cycles; pad it back into alignment
  for (genvar i = 0; i < M; i++) begin : g_desk
    localparam int D = M - 1 - i;
    if (D == 0) begin : g_direct
      assign out_data[i*ACC_W +: ACC_W] = ps_bus[i][K-1];
    end else begin : g_reg
      logic [ACC_W-1:0] dr [D];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int j = 0; j < D; j++) dr[j] <= '0;
        end else if (adv) begin
          dr[0] <= ps_bus[i][K-1];
          for (int j = 1; j < D; j++) dr[j] <= dr[j-1];
        end
      end
      assign out_data[i*ACC_W +: ACC_W] = dr[D-1];
    end
  end

endmodule
